load_store_unit: RTL and testbench

//  Sits between the CPU execute stage and the word-only data memory, which has 1-cycle registered reads.

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data memory
// with 1-cycle registered reads. Handles byte/half/word loads (zero- or
// sign-extended) and stores; sub-word stores use read-modify-write.
// Misaligned, reserved-size and out-of-range requests respond with an
// error and never touch memory.
module load_store_unit #(
  parameter int MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_en,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LWAIT = 3'd1,
    RMW   = 3'd2,
    ERR   = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        accept;
  logic        misalign;
  logic        bad;
  logic        word_store;

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of a memory word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = data[7:0];
          2'b01:   r[15:8]  = data[7:0];
          2'b10:   r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          r[31:16] = data[15:0];
        end else begin
          r[15:0] = data[15:0];
        end
      end
      default: r = data;
    endcase
    return r;
  endfunction

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign word_store = req_write && (req_size == 2'b10);

  // Classify the incoming request as a bad access.
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
    bad = misalign || (req_addr >= MEM_LIMIT);
  end

  // Memory-side drive: read/word-write in the accept cycle, merged write in RMW.
  always_comb begin
    mem_read_addr  = {addr_q[31:2], 2'b00};
    mem_write_addr = {addr_q[31:2], 2'b00};
    mem_write_data = wdata_q;
    mem_write_en   = 1'b0;
    if (accept && !bad) begin
      mem_read_addr = {req_addr[31:2], 2'b00};
      if (word_store) begin
        mem_write_en   = 1'b1;
        mem_write_addr = {req_addr[31:2], 2'b00};
        mem_write_data = req_wdata;
      end else begin
        mem_write_en = 1'b0;
      end
    end else if (state == RMW) begin
      mem_write_en   = 1'b1;
      mem_write_data = merge_lane(mem_read_data, wdata_q, addr_q[1:0], size_q);
    end else begin
      mem_write_en = 1'b0;
    end
    if (reset) begin
      mem_write_en = 1'b0;
    end else begin
      mem_write_en = mem_write_en;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            signed_q   <= req_signed;
            resp_rdata <= 32'd0;
            if (bad) begin
              state <= ERR;
            end else if (!req_write) begin
              state <= LWAIT;
            end else if (word_store) begin
              state <= RESP;
            end else begin
              state <= RMW;
            end
          end
        end
        LWAIT: begin
          resp_rdata <= extract_lane(mem_read_data, addr_q[1:0], size_q, signed_q);
          state      <= RESP;
        end
        RMW: begin
          state <= RESP;
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= 32'd0;
          state      <= IDLE;
        end
        RESP: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed reference memory
// model, a word-wide memory with registered reads, directed requests, and a
// single negedge compare process.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic        mem_write_en;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;

  load_store_unit #(.MEM_SIZE(4096)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  // Word memory with 1-cycle registered read.
  logic [31:0] mem [0:1023];
  logic [9:0]  ridx;
  logic [9:0]  widx;
  assign ridx = 10'(mem_read_addr >> 2);
  assign widx = 10'(mem_write_addr >> 2);
  always @(posedge clk) begin
    mem_read_data <= mem[ridx];
    if (mem_write_en) mem[widx] <= mem_write_data;
  end

  // Reference model: plain byte array.
  logic [7:0] ref_mem [0:4095];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectations (written only by the stimulus side).
  int          txn_id = 0;
  int          mode = 3;      // 0 idle, 1 expect response, 2 abort window, 3 reset/idle state
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;
  int          exp_writes = 0;
  logic [31:0] exp_waddr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic        lit_en = 1'b0;
  logic [31:0] lit_val = 32'd0;

  // Results (written only by the compare process).
  int checks = 0;
  int errors = 0;
  int resp_id = 0;
  int cur_id = 0;
  int wcount = 0;

  task automatic fail(input string name, input logic [31:0] got, input logic [31:0] want);
    errors++;
    $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) fail(name, got, want);
  endtask

  // Compare process: checks DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (cur_id != txn_id) begin
      cur_id = txn_id;
      wcount = 0;
    end
    case (mode)
      1: begin
        if (mem_write_en) begin
          wcount++;
          chk("write_addr", mem_write_addr, exp_waddr);
          chk("write_data", mem_write_data, exp_wdata);
        end
        if (resp_valid) begin
          if (resp_id == txn_id) begin
            fail("extra_resp", 32'd1, 32'd0);
          end else begin
            resp_id = txn_id;
            chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
            chk("ready_at_resp", {31'd0, req_ready}, 32'd1);
            chk("write_count", 32'(wcount), 32'(exp_writes));
            if (lit_en) chk("literal", resp_rdata, lit_val);
          end
        end else if (resp_id != txn_id && cyc > acc_cyc + 10) begin
          resp_id = txn_id;
          fail("timeout", 32'(cyc - acc_cyc), 32'(exp_lat));
        end
      end
      2: begin
        chk("abort_write_en", {31'd0, mem_write_en}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
      end
      3: begin
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_resp_err", {31'd0, resp_err}, 32'd0);
        chk("idle_resp_rdata", resp_rdata, 32'd0);
        chk("idle_write_en", {31'd0, mem_write_en}, 32'd0);
      end
      default: begin
        if (resp_valid) fail("spurious_resp", 32'd1, 32'd0);
        if (mem_write_en) fail("spurious_write", 32'd1, 32'd0);
      end
    endcase
  end

  // Issue one request; model computes expectations from the access rules.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic le, input logic [31:0] lv);
    int nbytes;
    logic bad;
    logic [31:0] val;
    logic [31:0] wa;
    nbytes = 1 << sz;
    bad = (sz == 2'b11) || ((a % nbytes) != 0) || (a >= 32'd4096);
    val = 32'd0;
    wa = a & 32'hFFFF_FFFC;
    if (!bad && w) begin
      for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
      exp_wdata = {ref_mem[wa + 3], ref_mem[wa + 2], ref_mem[wa + 1], ref_mem[wa]};
      exp_waddr = wa;
    end else if (!bad) begin
      for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[a + i]) << (8 * i));
      if (sg && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
    end
    exp_err    = bad;
    exp_rdata  = (bad || w) ? 32'd0 : val;
    exp_lat    = (bad || (w && sz == 2'b10)) ? 1 : 2;
    exp_writes = (w && !bad) ? 1 : 0;
    lit_en     = le;
    lit_val    = lv;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    txn_id++;
    acc_cyc = cyc + 1;
    mode = 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 20 && resp_id != txn_id; k++) @(posedge clk);
    mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    mode = 3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    mode = 0;

    // Word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0,        1'b1, 32'h1122_3344);
    // Byte store (upper wdata bits must be ignored) then word load
    issue(1'b1, 2'b00, 1'b0, 32'h23, 32'h1234_56AB, 1'b0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0,         1'b1, 32'hAB22_3344);
    // Sub-word loads with extension
    issue(1'b0, 2'b00, 1'b1, 32'h23, 32'd0, 1'b1, 32'hFFFF_FFAB);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 1'b1, 32'h0000_AB22);
    issue(1'b0, 2'b01, 1'b1, 32'h20, 32'd0, 1'b1, 32'h0000_3344);
    // Half store to upper lane, then assorted loads
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_8001, 1'b0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b1, 32'h8001_3344);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 1'b1, 32'hFFFF_8001);
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 1'b1, 32'h0000_0033);
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0080, 1'b0, 32'd0);
    issue(1'b0, 2'b00, 1'b1, 32'h20, 32'd0, 1'b1, 32'hFFFF_FF80);
    // Bad accesses
    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'd0,         1'b1, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_BEEF, 1'b1, 32'd0);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'd0,         1'b1, 32'd0);
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'd0);
    // Range boundary
    issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFE_F00D, 1'b1, 32'd0);
    issue(1'b0, 2'b00, 1'b0, 32'h1000, 32'd0,         1'b1, 32'd0);
    issue(1'b1, 2'b10, 1'b0, 32'hFFC,  32'hDEAD_BEEF, 1'b0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFC,  32'd0, 1'b1, 32'hDEAD_BEEF);
    issue(1'b0, 2'b00, 1'b1, 32'hFFF,  32'd0, 1'b1, 32'hFFFF_FFDE);
    issue(1'b0, 2'b01, 1'b0, 32'hFFE,  32'd0, 1'b1, 32'h0000_DEAD);

    // Reset during RMW of byte store 0x55 to 0x20: aborted, no write
    @(posedge clk); #1;
    txn_id++;
    mode = 2;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mode = 3;
    repeat (2) @(posedge clk);
    mode = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b1, 32'h8001_3380);
    issue(1'b0, 2'b00, 1'b0, 32'h20, 32'd0, 1'b1, 32'h0000_0080);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want %0d", cyc, 0);
    $fatal(1, "simulation time limit");
  end

endmodule
